sram_arbiter: RTL and testbench

Sequences and shares the eLC-3's single 64K x 16 SRAM between two requesters: the CPU memory port and the video frame reader. Runs a fixed multi-cycle SRAM access (setup, strobe, hold) with request/acknowledge handshakes on each side. Drives active-high, registered SRAM strobes that the existing memory control path inverts and synchronizes toward the chip pins. Video has priority, and a starvation guard bounds CPU wait.

---
 rtl/sram_arb_pkg.sv | 8 +
 rtl/sram_arb_select.sv | 30 +++
 rtl/sram_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the eLC-3 SRAM arbiter.
package sram_arb_pkg;
  localparam int         CNT_W   = 4;
  localparam logic [6:0] IO_PAGE = 7'h7F;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  typedef enum logic {PORT_CPU, PORT_VID} port_t;
endpackage

// File: rtl/sram_arb_select.sv
// Winner selection between CPU and video, with the CPU starvation counter.
module sram_arb_select
  import sram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic vid_req,
  input  logic grant,
  output logic vid_win
);
  logic [CNT_W-1:0] starve_q;

  // Video wins unless the CPU has been passed over STARVE_LIMIT times in a row.
  assign vid_win = vid_req && !(cpu_req && (starve_q == CNT_W'(STARVE_LIMIT)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (grant) begin
      if (!vid_win) begin
        starve_q <= '0;
      end else if (cpu_req && (starve_q != '1)) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_arbiter.sv
// Shares the single 64K x 16 SRAM between CPU and video with a setup/strobe/hold access.
// Optional: SRAM_ARB_MMIO_BYPASS_EN makes CPU device-page accesses skip the SRAM.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        Cpu_Req,
  input  logic        Cpu_R_W,
  input  logic [15:0] Cpu_Addr,
  input  logic [15:0] Cpu_WData,
  output logic [15:0] Cpu_RData,
  output logic        Cpu_Ack,
  input  logic        Vid_Req,
  input  logic        Vid_R_W,
  input  logic [15:0] Vid_Addr,
  input  logic [15:0] Vid_WData,
  output logic [15:0] Vid_RData,
  output logic        Vid_Ack,
  output logic        Mem_CE,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic [19:0] Mem_Addr,
  output logic [15:0] Mem_WData,
  input  logic [15:0] Mem_RData,
  output logic        Busy
);
  state_t           state_q, state_nxt;
  port_t            port_q, winner, port_eff;
  logic             vid_win, grant, sram_grant, bypass, is_io;
  logic             rw_q, sel_rw, rw_eff;
  logic             ce_nxt, oe_nxt, we_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      addr_q, wdata_q;

  sram_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clk     (Clk),
    .rst_n   (Reset_N),
    .cpu_req (Cpu_Req),
    .vid_req (Vid_Req),
    .grant   (sram_grant),
    .vid_win (vid_win)
  );

  assign winner = vid_win ? PORT_VID : PORT_CPU;
  assign sel_rw = vid_win ? Vid_R_W : Cpu_R_W;

`ifdef SRAM_ARB_MMIO_BYPASS_EN
  assign is_io = (Cpu_Addr[15:9] == IO_PAGE);
`else
  assign is_io = 1'b0;
`endif

  assign Busy      = (state_q != IDLE);
  assign Mem_Addr  = {4'b0000, addr_q};
  assign Mem_WData = wdata_q;

  always_comb begin
    state_nxt  = state_q;
    grant      = 1'b0;
    sram_grant = 1'b0;
    bypass     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Cpu_Req || Vid_Req) begin
          grant = 1'b1;
          // Device-page CPU accesses never touch the SRAM or the starve counter.
          if ((winner == PORT_CPU) && is_io) begin
            bypass    = 1'b1;
            state_nxt = HOLD;
          end else begin
            sram_grant = 1'b1;
            state_nxt  = SETUP;
          end
        end
      end
      SETUP:   state_nxt = STROBE;
      STROBE:  if (cnt_q == '0) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and acks are registered, so they are derived from the next state.
  always_comb begin
    rw_eff   = grant ? sel_rw : rw_q;
    port_eff = grant ? winner : port_q;
    ce_nxt   = 1'b0;
    oe_nxt   = 1'b0;
    we_nxt   = 1'b0;
    case (state_nxt)
      SETUP: begin
        ce_nxt = 1'b1;
        oe_nxt = rw_eff;
      end
      STROBE: begin
        ce_nxt = 1'b1;
        oe_nxt = rw_eff;
        we_nxt = ~rw_eff;
      end
      HOLD:    ce_nxt = (state_q == STROBE);
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q   <= IDLE;
      port_q    <= PORT_CPU;
      rw_q      <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      Mem_CE    <= 1'b0;
      Mem_OE    <= 1'b0;
      Mem_WE    <= 1'b0;
      Cpu_Ack   <= 1'b0;
      Vid_Ack   <= 1'b0;
      Cpu_RData <= '0;
      Vid_RData <= '0;
    end else begin
      state_q <= state_nxt;
      Mem_CE  <= ce_nxt;
      Mem_OE  <= oe_nxt;
      Mem_WE  <= we_nxt;
      Cpu_Ack <= (state_nxt == HOLD) && (port_eff == PORT_CPU);
      Vid_Ack <= (state_nxt == HOLD) && (port_eff == PORT_VID);
      if (grant) begin
        port_q <= winner;
        rw_q   <= sel_rw;
      end
      if (sram_grant) begin
        addr_q  <= vid_win ? Vid_Addr : Cpu_Addr;
        wdata_q <= vid_win ? Vid_WData : Cpu_WData;
      end
      if (state_q == SETUP) begin
        cnt_q <= CNT_W'(ACCESS_CYCLES - 1);
      end else if ((state_q == STROBE) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (bypass) begin
        Cpu_RData <= '0;
      end
      if ((state_q == STROBE) && (cnt_q == '0) && rw_q) begin
        if (port_q == PORT_CPU) Cpu_RData <= Mem_RData;
        else                    Vid_RData <= Mem_RData;
      end
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed accesses, contention, reset abort, device page.
module tb_sram_arbiter;
  localparam int ACCESS_CYCLES = 2;
  localparam int STARVE_LIMIT  = 3;
  localparam int LAT           = ACCESS_CYCLES + 2;

  logic        Clk = 1'b0;
  logic        Reset_N = 1'b0;
  logic        Cpu_Req = 1'b0, Cpu_R_W = 1'b0;
  logic [15:0] Cpu_Addr = '0, Cpu_WData = '0;
  logic [15:0] Cpu_RData;
  logic        Cpu_Ack;
  logic        Vid_Req = 1'b0, Vid_R_W = 1'b0;
  logic [15:0] Vid_Addr = '0, Vid_WData = '0;
  logic [15:0] Vid_RData;
  logic        Vid_Ack;
  logic        Mem_CE, Mem_OE, Mem_WE;
  logic [19:0] Mem_Addr;
  logic [15:0] Mem_WData, Mem_RData;
  logic        Busy;

  sram_arbiter #(.ACCESS_CYCLES(ACCESS_CYCLES), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .Cpu_Req(Cpu_Req), .Cpu_R_W(Cpu_R_W), .Cpu_Addr(Cpu_Addr), .Cpu_WData(Cpu_WData),
    .Cpu_RData(Cpu_RData), .Cpu_Ack(Cpu_Ack),
    .Vid_Req(Vid_Req), .Vid_R_W(Vid_R_W), .Vid_Addr(Vid_Addr), .Vid_WData(Vid_WData),
    .Vid_RData(Vid_RData), .Vid_Ack(Vid_Ack),
    .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_RData(Mem_RData), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  logic [15:0] mem [0:65535];
  assign Mem_RData = mem[Mem_Addr[15:0]];
  always @(posedge Clk) if (Mem_WE) mem[Mem_Addr[15:0]] <= Mem_WData;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic        vid;
    logic        rd;
    logic [15:0] rdata;
    int          exp_cyc;
    int          ce_n;
    int          oe_n;
    int          we_n;
    logic [15:0] addr;
  } exp_t;

  exp_t sbq[$];

  task automatic push_exp(input logic vid, input logic rd, input logic [15:0] rdata,
                          input int exp_cyc, input int ce_n, input int oe_n, input int we_n,
                          input logic [15:0] addr);
    exp_t e;
    e.vid = vid; e.rd = rd; e.rdata = rdata; e.exp_cyc = exp_cyc;
    e.ce_n = ce_n; e.oe_n = oe_n; e.we_n = we_n; e.addr = addr;
    sbq.push_back(e);
  endtask

  // Monitor: accumulate strobe activity per access and score each Ack.
  int   ce_cnt = 0, oe_cnt = 0, we_cnt = 0;
  logic we_bad = 1'b0, prev_ack = 1'b0;
  exp_t m;
  always @(negedge Clk) begin
    if (!Reset_N) begin
      ce_cnt = 0; oe_cnt = 0; we_cnt = 0; we_bad = 1'b0; prev_ack = 1'b0;
    end else begin
      if (Mem_CE) begin
        if (ce_cnt == 0 && Mem_WE) we_bad = 1'b1;
        ce_cnt++;
        if (Mem_OE) oe_cnt++;
        if (Mem_WE) we_cnt++;
      end
      if (Mem_WE && (!Mem_CE || Mem_OE)) we_bad = 1'b1;
      if (Cpu_Ack || Vid_Ack) begin
        if (Mem_WE) we_bad = 1'b1;
        chk("ack_one_cycle", prev_ack, 1'b0);
        chk("ack_exclusive", Cpu_Ack & Vid_Ack, 1'b0);
        if (sbq.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          m = sbq.pop_front();
          chk("ack_port", Vid_Ack, m.vid);
          if (m.rd) chk("rdata", m.vid ? Vid_RData : Cpu_RData, m.rdata);
          if (m.exp_cyc >= 0) chk("ack_cycle", cyc, m.exp_cyc);
          chk("ce_cycles", ce_cnt, m.ce_n);
          chk("oe_cycles", oe_cnt, m.oe_n);
          chk("we_cycles", we_cnt, m.we_n);
          chk("we_outside_strobe", we_bad, 1'b0);
          if (m.ce_n != 0) chk("mem_addr", Mem_Addr, {4'h0, m.addr});
        end
        ce_cnt = 0; oe_cnt = 0; we_cnt = 0; we_bad = 1'b0;
      end
      prev_ack = Cpu_Ack | Vid_Ack;
    end
  end

  task automatic do_access(input logic vid, input logic rw, input logic [15:0] addr,
                           input logic [15:0] wd, input logic [15:0] rd_exp,
                           input int lat, input int ce_n, input int oe_n, input int we_n,
                           input logic drop_early);
    logic got;
    @(negedge Clk);
    if (vid) begin Vid_R_W = rw; Vid_Addr = addr; Vid_WData = wd; Vid_Req = 1'b1; end
    else     begin Cpu_R_W = rw; Cpu_Addr = addr; Cpu_WData = wd; Cpu_Req = 1'b1; end
    push_exp(vid, rw, rd_exp, cyc + lat, ce_n, oe_n, we_n, addr);
    if (drop_early) begin
      @(negedge Clk);
      Cpu_Req = 1'b0; Vid_Req = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      got = vid ? Vid_Ack : Cpu_Ack;
    end
    if (!got) chk("ack_timeout", 0, 1);
    Cpu_Req = 1'b0; Vid_Req = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int acks;
    int seen;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h3000] = 16'hBEEF;
    mem[16'h5000] = 16'hCAFE;
    mem[16'h5001] = 16'h7777;
    mem[16'h6000] = 16'hC0C0;
    mem[16'h6001] = 16'h0D0D;
    mem[16'hFE02] = 16'hABCD;

    repeat (3) @(negedge Clk);
    chk("rst_ce", Mem_CE, 0);
    chk("rst_oe", Mem_OE, 0);
    chk("rst_we", Mem_WE, 0);
    chk("rst_addr", Mem_Addr, 0);
    chk("rst_wdata", Mem_WData, 0);
    chk("rst_cpu_rdata", Cpu_RData, 0);
    chk("rst_vid_rdata", Vid_RData, 0);
    chk("rst_acks", {Cpu_Ack, Vid_Ack}, 0);
    chk("rst_busy", Busy, 0);
    Reset_N = 1'b1;
    @(negedge Clk);

    // CPU read, CPU write, CPU read with Req dropped right after the grant.
    do_access(1'b0, 1'b1, 16'h3000, 16'h0000, 16'hBEEF, LAT, 4, 3, 0, 1'b0);
    do_access(1'b0, 1'b0, 16'h4001, 16'h1234, 16'h0000, LAT, 4, 0, 2, 1'b0);
    chk("write_mem", mem[16'h4001], 16'h1234);
    chk("rdata_kept_after_write", Cpu_RData, 16'hBEEF);
    do_access(1'b0, 1'b1, 16'h3000, 16'h0000, 16'hBEEF, LAT, 4, 3, 0, 1'b1);

    do_access(1'b1, 1'b1, 16'h5000, 16'h0000, 16'hCAFE, LAT, 4, 3, 0, 1'b0);
    chk("cpu_rdata_untouched_by_vid", Cpu_RData, 16'hBEEF);

    // Reset in the middle of a video read strobe.
    @(negedge Clk);
    Vid_R_W = 1'b1; Vid_Addr = 16'h5001; Vid_Req = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    #2 Reset_N = 1'b0;
    #1;
    chk("abort_ce", Mem_CE, 0);
    chk("abort_oe", Mem_OE, 0);
    chk("abort_we", Mem_WE, 0);
    chk("abort_vid_rdata", Vid_RData, 0);
    chk("abort_cpu_rdata", Cpu_RData, 0);
    chk("abort_busy", Busy, 0);
    Vid_Req = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_N = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge Clk);
      if (Vid_Ack || Cpu_Ack) seen++;
    end
    chk("abort_no_ack", seen, 0);
    do_access(1'b1, 1'b1, 16'h5001, 16'h0000, 16'h7777, LAT, 4, 3, 0, 1'b0);

    // Both requesters held: V,V,V,C,V,V,V,C.
    @(negedge Clk);
    Cpu_R_W = 1'b1; Cpu_Addr = 16'h6000;
    Vid_R_W = 1'b1; Vid_Addr = 16'h6001;
    for (int k = 0; k < 8; k++) begin
      if (k == 3 || k == 7) push_exp(1'b0, 1'b1, 16'hC0C0, -1, 4, 3, 0, 16'h6000);
      else                  push_exp(1'b1, 1'b1, 16'h0D0D, -1, 4, 3, 0, 16'h6001);
    end
    Cpu_Req = 1'b1; Vid_Req = 1'b1;
    acks = 0;
    for (int i = 0; i < 100 && acks < 8; i++) begin
      @(negedge Clk);
      if (Cpu_Ack || Vid_Ack) acks++;
    end
    Cpu_Req = 1'b0; Vid_Req = 1'b0;
    chk("contention_acks", acks, 8);
    repeat (2) @(negedge Clk);

    // Device-page CPU read.
`ifdef SRAM_ARB_MMIO_BYPASS_EN
    do_access(1'b0, 1'b1, 16'hFE02, 16'h0000, 16'h0000, 1, 0, 0, 0, 1'b0);
`else
    do_access(1'b0, 1'b1, 16'hFE02, 16'h0000, 16'hABCD, LAT, 4, 3, 0, 1'b0);
`endif

    repeat (3) @(negedge Clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
